bus_arb2: RTL and testbench

Two-requester arbiter that shares a single local-bus target (addr / wdata / rdata / wstb) between two masters. Each master issues one transaction at a time with a req/ack handshake. The block sequences the shared bus: strobe for writes, fixed-latency wait and capture for reads. Contention is resolved round-robin. It sits between two bus hosts and one bus decoder/peripheral tree on a single clock domain.

---
 rtl/bus_arb2_if.sv | 35 +++
 rtl/bus_arb2.sv | 73 +++++++
 tb/tb_bus_arb2.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/bus_arb2_if.sv
// bus_arb2_if: requester handshakes plus shared local-bus signals for bus_arb2.
// master is the arbiter side; slave is the requesters/target side.
interface bus_arb2_if #(
    parameter int AW = 24,
    parameter int DW = 32
);
    logic          a_req;
    logic          a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata;
    logic [DW-1:0] a_rdata;
    logic          a_ack;
    logic          b_req;
    logic          b_we;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    logic [DW-1:0] b_rdata;
    logic          b_ack;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_wdata;
    logic          o_wstb;
    logic [DW-1:0] o_rdata;
    logic          owner;
    logic          busy;

    modport master (
        input  a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, o_rdata,
        output a_rdata, a_ack, b_rdata, b_ack, o_addr, o_wdata, o_wstb, owner, busy
    );

    modport slave (
        output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, o_rdata,
        input  a_rdata, a_ack, b_rdata, b_ack, o_addr, o_wdata, o_wstb, owner, busy
    );
endinterface

// File: rtl/bus_arb2.sv
// bus_arb2: round-robin arbiter sharing one local-bus target between two req/ack masters.
module bus_arb2 #(
    parameter int RD_LAT = 1
) (
    input logic        clk,
    input logic        rst_n,
    bus_arb2_if.master bus
);
    typedef enum logic [1:0] {IDLE, BUS, WAIT, ACK} state_t;

    state_t     state;
    logic       we;
    logic [3:0] cnt;
    logic       pick_b;

    // B wins when alone, or on contention when A was granted last
    assign pick_b = bus.b_req & (~bus.a_req | ~bus.owner);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            we          <= 1'b0;
            cnt         <= '0;
            bus.o_addr  <= '0;
            bus.o_wdata <= '0;
            bus.o_wstb  <= 1'b0;
            bus.a_rdata <= '0;
            bus.b_rdata <= '0;
            bus.a_ack   <= 1'b0;
            bus.b_ack   <= 1'b0;
            bus.busy    <= 1'b0;
            bus.owner   <= 1'b1;
        end else begin
            bus.o_wstb <= 1'b0;
            bus.a_ack  <= 1'b0;
            bus.b_ack  <= 1'b0;
            case (state)
                IDLE: if (bus.a_req | bus.b_req) begin
                    state       <= BUS;
                    bus.busy    <= 1'b1;
                    bus.owner   <= pick_b;
                    we          <= pick_b ? bus.b_we : bus.a_we;
                    bus.o_wstb  <= pick_b ? bus.b_we : bus.a_we;
                    bus.o_addr  <= pick_b ? bus.b_addr : bus.a_addr;
                    bus.o_wdata <= pick_b ? bus.b_wdata : bus.a_wdata;
                end
                BUS: if (we) begin
                    state     <= ACK;
                    bus.a_ack <= ~bus.owner;
                    bus.b_ack <= bus.owner;
                end else begin
                    state <= WAIT;
                    cnt   <= 4'(RD_LAT);
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state     <= ACK;
                        bus.a_ack <= ~bus.owner;
                        bus.b_ack <= bus.owner;
                        if (bus.owner) bus.b_rdata <= bus.o_rdata;
                        else bus.a_rdata <= bus.o_rdata;
                    end
                end
                ACK: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_arb2.sv
// tb_bus_arb2: directed vectors for bus_arb2 (RD_LAT=3) against a fixed-latency target model.
module tb_bus_arb2;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    int wstb_n = 0;
    int a_ack_n = 0;
    int b_ack_n = 0;
    logic busy_prev = 1'b0;
    logic [2:0] st = '0;
    logic [24:0] wq[$];

    bus_arb2_if #(.AW(24), .DW(32)) bus();
    bus_arb2 #(.RD_LAT(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // target returns data exactly 3 cycles after a new address, garbage otherwise
    always @(posedge clk) begin
        busy_prev <= bus.busy;
        st <= {st[1:0], bus.busy & ~busy_prev};
    end
    assign bus.o_rdata = !st[2] ? 32'hBAD0BAD0 :
                         (bus.o_addr == 24'h000020) ? 32'h12345678 : {8'h5A, bus.o_addr};

    always @(negedge clk) begin
        if (bus.o_wstb) begin
            wstb_n <= wstb_n + 1;
            wq.push_back({bus.owner, bus.o_addr});
        end
        if (bus.a_ack) a_ack_n <= a_ack_n + 1;
        if (bus.b_ack) b_ack_n <= b_ack_n + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, " o_addr"}, 32'(bus.o_addr), 32'h0);
        check({tag, " o_wdata"}, bus.o_wdata, 32'h0);
        check({tag, " o_wstb"}, 32'(bus.o_wstb), 32'h0);
        check({tag, " a_rdata"}, bus.a_rdata, 32'h0);
        check({tag, " b_rdata"}, bus.b_rdata, 32'h0);
        check({tag, " a_ack"}, 32'(bus.a_ack), 32'h0);
        check({tag, " b_ack"}, 32'(bus.b_ack), 32'h0);
        check({tag, " busy"}, 32'(bus.busy), 32'h0);
        check({tag, " owner"}, 32'(bus.owner), 32'h1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not end within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int w0, a0, b0, q0;
        logic [24:0] e;
        {bus.a_req, bus.a_we, bus.b_req, bus.b_we} = '0;
        bus.a_addr = '0; bus.a_wdata = '0; bus.b_addr = '0; bus.b_wdata = '0;
        tick(2);
        rst_n = 1'b1;
        check_reset("rst");

        // single write from A
        w0 = wstb_n; b0 = b_ack_n;
        bus.a_req = 1; bus.a_we = 1; bus.a_addr = 24'h000010; bus.a_wdata = 32'hDEADBEEF;
        tick(1);
        check("wr wstb", 32'(bus.o_wstb), 32'h1);
        check("wr addr", 32'(bus.o_addr), 32'h10);
        check("wr wdata", bus.o_wdata, 32'hDEADBEEF);
        check("wr owner", 32'(bus.owner), 32'h0);
        check("wr busy", 32'(bus.busy), 32'h1);
        check("wr early ack", 32'(bus.a_ack), 32'h0);
        tick(1);
        check("wr a_ack", 32'(bus.a_ack), 32'h1);
        check("wr wstb off", 32'(bus.o_wstb), 32'h0);
        bus.a_req = 0;
        tick(1);
        check("wr ack pulse", 32'(bus.a_ack), 32'h0);
        check("wr idle busy", 32'(bus.busy), 32'h0);
        check("wr addr hold", 32'(bus.o_addr), 32'h10);
        check("wr wstb count", 32'(wstb_n - w0), 32'd1);
        check("wr b_ack none", 32'(b_ack_n - b0), 32'd0);

        // single read from B
        w0 = wstb_n;
        bus.b_req = 1; bus.b_we = 0; bus.b_addr = 24'h000020;
        tick(1);
        check("rd addr", 32'(bus.o_addr), 32'h20);
        check("rd owner", 32'(bus.owner), 32'h1);
        tick(3);
        check("rd early ack", 32'(bus.b_ack), 32'h0);
        tick(1);
        check("rd b_ack", 32'(bus.b_ack), 32'h1);
        check("rd b_rdata", bus.b_rdata, 32'h12345678);
        check("rd a_rdata", bus.a_rdata, 32'h0);
        bus.b_req = 0;
        tick(1);
        check("rd b_rdata hold", bus.b_rdata, 32'h12345678);
        check("rd no wstb", 32'(wstb_n - w0), 32'd0);

        // simultaneous requests right after reset
        rst_n = 0;
        tick(1);
        rst_n = 1;
        check_reset("rst2");
        bus.a_req = 1; bus.a_we = 1; bus.a_addr = 24'h000100; bus.a_wdata = 32'hA;
        bus.b_req = 1; bus.b_we = 1; bus.b_addr = 24'h000200; bus.b_wdata = 32'hB;
        tick(1);
        check("sim 1st owner", 32'(bus.owner), 32'h0);
        check("sim 1st addr", 32'(bus.o_addr), 32'h100);
        check("sim 1st wstb", 32'(bus.o_wstb), 32'h1);
        tick(1);
        check("sim a_ack", 32'(bus.a_ack), 32'h1);
        bus.a_req = 0;
        tick(2);
        check("sim 2nd wstb", 32'(bus.o_wstb), 32'h1);
        check("sim 2nd owner", 32'(bus.owner), 32'h1);
        check("sim 2nd addr", 32'(bus.o_addr), 32'h200);
        check("sim 2nd wdata", bus.o_wdata, 32'hB);
        tick(1);
        check("sim b_ack", 32'(bus.b_ack), 32'h1);
        bus.b_req = 0;
        tick(1);

        // saturation: both hold req for 8 back-to-back writes, owner is 1 so A first
        w0 = wstb_n; a0 = a_ack_n; b0 = b_ack_n; q0 = wq.size();
        bus.a_req = 1; bus.a_addr = 24'h000300;
        bus.b_req = 1; bus.b_addr = 24'h000400;
        tick(23);
        bus.a_req = 0; bus.b_req = 0;
        tick(3);
        check("sat wstb count", 32'(wstb_n - w0), 32'd8);
        check("sat a_ack count", 32'(a_ack_n - a0), 32'd4);
        check("sat b_ack count", 32'(b_ack_n - b0), 32'd4);
        for (int k = 0; k < 8; k++) begin
            e = (q0 + k < wq.size()) ? wq[q0 + k] : 25'h1FFFFFF;
            check($sformatf("sat owner %0d", k), 32'(e[24]), 32'(k % 2));
            check($sformatf("sat addr %0d", k), 32'(e[23:0]), (k % 2) ? 32'h400 : 32'h300);
        end

        // reset in the middle of A's read, then a fresh A read
        a0 = a_ack_n;
        bus.a_req = 1; bus.a_we = 0; bus.a_addr = 24'h000050;
        tick(2);
        rst_n = 0;
        tick(1);
        rst_n = 1;
        check_reset("rst mid");
        check("rst mid no ack", 32'(a_ack_n - a0), 32'd0);
        tick(1);
        check("rst re owner", 32'(bus.owner), 32'h0);
        check("rst re addr", 32'(bus.o_addr), 32'h50);
        tick(4);
        check("rst re a_ack", 32'(bus.a_ack), 32'h1);
        check("rst re a_rdata", bus.a_rdata, 32'h5A000050);
        bus.a_req = 0;
        tick(1);

        // A changes its address during WAIT; the latched one must be kept
        bus.a_req = 1; bus.a_we = 0; bus.a_addr = 24'h000060;
        tick(2);
        bus.a_addr = 24'h000999;
        check("stab wait addr", 32'(bus.o_addr), 32'h60);
        tick(3);
        check("stab ack", 32'(bus.a_ack), 32'h1);
        check("stab ack addr", 32'(bus.o_addr), 32'h60);
        check("stab a_rdata", bus.a_rdata, 32'h5A000060);
        check("stab b_ack", 32'(bus.b_ack), 32'h0);
        bus.a_req = 0;
        tick(1);
        check("stab idle addr", 32'(bus.o_addr), 32'h60);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
